// File: rtl/pc_pkg.sv
// Shared types for the program counter with hardware return stack.
// Holds the operation encoding and the control priority resolver.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET
    } pc_op_t;

    // Several controls may be high at once; ret wins, then call, lp, cp.
    function automatic pc_op_t pc_resolve(
        input logic ret,
        input logic call,
        input logic lp,
        input logic cp
    );
        pc_op_t op;
        if (ret) begin
            op = PC_RET;
        end else if (call) begin
            op = PC_CALL;
        end else if (lp) begin
            op = PC_LOAD;
        end else if (cp) begin
            op = PC_INC;
        end else begin
            op = PC_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_call_stack_if.sv
// Control and status bundle between the sequencer and the program counter.
// The shared data bus stays a plain inout net on the top level.
interface pc_call_stack_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
);
    logic             lp;
    logic             cp;
    logic             ep;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [SPW-1:0]   sp;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;

    modport master (
        output lp, cp, ep, call, ret,
        input  pc, sp, full, empty, ovf, unf
    );

    modport slave (
        input  lp, cp, ep, call, ret,
        output pc, sp, full, empty, ovf, unf
    );
endinterface

// File: rtl/return_stack.sv
// LIFO of return addresses; ignores push when full and pop when empty.
// rdata always shows the top entry (zero while empty).
module return_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;

    assign sp    = sp_q;
    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        rdata = '0;
        // Compare on the pointer width to avoid sizing the array index.
        for (int i = 0; i < DEPTH; i++) begin
            if (SPW'(i) == sp_q - SPW'(1)) begin
                rdata = mem_q[i];
            end
        end
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (SPW'(i) == sp_q) begin
                    mem_d[i] = wdata;
                end
            end
            sp_d = sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q <= sp_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: rtl/pc_call_stack.sv
// Program counter with bus load/drive and a hardware CALL/RET stack.
// The bus is driven from the live pc while the registered ep is set.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    inout  wire  [WIDTH-1:0] bus,
    pc_call_stack_if.slave   ctl
);
    pc_op_t           op;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             drv_q;
    logic             drv_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] top;
    logic [SPW-1:0]   sp;
    logic             full;
    logic             empty;

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .clk   (clk),
        .rst   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (pc_q + WIDTH'(1)),
        .rdata (top),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        op    = pc_resolve(ctl.ret, ctl.call, ctl.lp, ctl.cp);
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        drv_d = ctl.ep;
        unique case (op)
            PC_RET: begin
                if (!empty) begin
                    pc_d = top;
                    pop  = 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
            end
            PC_CALL: begin
                if (!full) begin
                    pc_d = bus;
                    push = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            PC_LOAD: pc_d = bus;
            PC_INC:  pc_d = pc_q + WIDTH'(1);
            PC_HOLD: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q  <= '0;
            drv_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            drv_q <= drv_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus       = drv_q ? pc_q : {WIDTH{1'bz}};
    assign ctl.pc    = pc_q;
    assign ctl.sp    = sp;
    assign ctl.full  = full;
    assign ctl.empty = empty;
    assign ctl.ovf   = ovf_q;
    assign ctl.unf   = unf_q;
endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised program counter for the SAP-style datapath: a WIDTH-bit counter that increments, loads a jump target from the shared tri-state bus, and drives its value back onto the bus on request. It also holds a DEPTH-entry hardware return-address stack, so CALL/RET work without memory traffic. It replaces the fixed 4-bit counter and sits between the control sequencer and the bus.

## Interface
- WIDTH, 4: counter and bus width; must be at least 2.
- DEPTH, 4: return-stack entries; must be at least 1.
- SPW, $clog2(DEPTH+1): derived stack-pointer width; do not override.

- clk  input  1  single clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- bus  inout  WIDTH  shared bus; read on load and call, driven when output is enabled.
- lp  input  1  load PC from bus.
- cp  input  1  count: PC <= PC+1.
- ep  input  1  request to drive PC onto bus; registered.
- call  input  1  push PC+1 onto the stack, then load PC from bus.
- ret  input  1  pop the stack top into PC.
- pc  output  WIDTH  current PC, for observation.
- sp  output  SPW  occupied stack entries, 0..DEPTH.
- full  output  1  sp == DEPTH.
- empty  output  1  sp == 0.
- ovf  output  1  sticky: a call was attempted while full.
- unf  output  1  sticky: a ret was attempted while empty.

## Operation
- Reset (clr high, asynchronous):
  - pc=0, sp=0, drive-enable register=0, so the bus is Z.
  - ovf=0, unf=0; all stack entries=0.
- Per rising edge, exactly one operation is selected. Priority is ret > call > lp > cp > hold.
- RET:
  - If not empty: pc <= stack[sp-1], sp <= sp-1.
  - If empty: pc unchanged, unf <= 1.
- CALL:
  - If not full: stack[sp] <= pc+1 (mod 2^WIDTH), sp <= sp+1, pc <= bus.
  - If full: pc and stack unchanged, ovf <= 1.
- LOAD: pc <= bus.
- COUNT: pc <= pc+1 (mod 2^WIDTH). All-ones wraps to 0 and no flag is raised.
- HOLD: no state change.
- Bus output:
  - The drive-enable register takes ep each edge.
  - While it is 1, bus = pc (the live value, combinational from the pc register); otherwise bus = Z.
- ovf and unf clear only on clr.
- full and empty are combinational from sp.

## Timing
- Load, count, call and ret: the new pc is visible 1 cycle after the edge that sampled the control.
- ep sampled high at edge N: bus is driven from just after edge N until just after the first edge that samples ep low.
- If pc changes while the bus is driven, the bus follows pc in the same cycle.
- The sequencer must not assert lp or call in a cycle where this block drives the bus. The sampled value is then undefined; the bench flags it with an assertion.
- Simultaneous controls resolve by priority. Example: lp and cp together performs a load.
- A call when sp = DEPTH-1 succeeds and full rises the next cycle.
- A ret when sp = 1 succeeds and empty rises the next cycle.
- clr asserted mid-operation aborts the operation immediately, with no partial push or pop. The first operation after reset uses the edge following clr deassertion.

## Structure
- Shared package pc_pkg holds:
  - an enum pc_op_t: PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET;
  - a function that resolves priority from (ret, call, lp, cp) to pc_op_t.
- Sub-module return_stack (LIFO, parameters WIDTH and DEPTH):
  - inputs: push, pop, wdata;
  - outputs: rdata (top entry), sp, full, empty;
  - it ignores push when full and pop when empty.
- The top level holds the pc register, the op decode, the drive-enable register, the sticky flags and the tri-state assignment.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset then 3 cycles of cp: pc=0x03. From pc=0xFF, one cp gives pc=0x00.
- Bus=0x40 with lp: pc=0x40 next cycle. Assert ep: bus reads 0x40 from the following cycle, and Z one cycle after ep drops.
- Calls:
  - At pc=0x10, call with bus=0x80: pc=0x80, sp=1, stack[0]=0x11.
  - Call with bus=0x90: pc=0x90, sp=2.
  - Two rets: pc=0x81, then pc=0x11, empty=1.
- Stack limits:
  - 4 calls: full=1. A 5th call leaves pc unchanged and sets ovf=1.
  - 4 rets then a 5th ret: pc unchanged and unf=1.
  - Both flags hold until clr.
- Priority: assert ret, call, lp and cp together with sp=1 and top=0x22: pc=0x22, sp=0. Assert lp and cp with bus=0x05: pc=0x05.
- Assert clr asynchronously between edges during a call sequence: pc, sp, ovf, unf and the bus drive (Z) are reset before the next edge.
